adrv9001_tdd_seq: RTL and testbench

Parametrised multi-channel TDD sequencer and transmit data gate for ADRV9001/2 SSI transmit paths, running in the divided data-clock domain (`dclk_div`). A prescaled frame counter is started by `tdd_en`. Per-channel compare windows against that counter drive the RF `enable` and the serdes/unpack reset. The block also muxes constant versus AXI-stream data per channel and flags stream underflow while the SSI window is open. It generalises the single-channel, one-shot, fixed divide-by-2 sequencing to N channels, a configurable prescale, and optional periodic frames.

---
 rtl/adrv9001_tdd_seq.sv | 115 +++++++++++
 tb/tb_adrv9001_tdd_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adrv9001_tdd_seq.sv
// rtl/adrv9001_tdd_seq.sv - multi-channel TDD sequencer and transmit data gate for the ADRV9001 SSI tx path
// Periodic frames via frame_len are compiled in only when ADRV9001_TDD_REPEAT_EN is defined.
module adrv9001_tdd_seq #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 32,
  parameter int DATA_W   = 32,
  parameter int PRESCALE = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   tdd_en,
  input  logic [CNT_W-1:0]       frame_len,
  input  logic [N_CH*CNT_W-1:0]  rf_on_cnt,
  input  logic [N_CH*CNT_W-1:0]  rf_off_cnt,
  input  logic [N_CH*CNT_W-1:0]  ssi_on_cnt,
  input  logic [N_CH*CNT_W-1:0]  ssi_off_cnt,
  input  logic [N_CH-1:0]        data_src,
  input  logic [N_CH*DATA_W-1:0] tdata,
  input  logic [N_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [N_CH-1:0]        s_axis_tvalid,
  output logic [N_CH-1:0]        s_axis_tready,
  output logic [N_CH*DATA_W-1:0] m_tdata,
  input  logic [N_CH-1:0]        m_tready,
  output logic [N_CH-1:0]        enable,
  output logic [N_CH-1:0]        ssi_rst,
  output logic [CNT_W-1:0]       cnt,
  output logic                   frame_done,
  output logic [N_CH-1:0]        underflow,
  input  logic                   underflow_clr
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PS_W-1:0]  ps_q, ps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;
  logic [N_CH-1:0]  enable_q, enable_d;
  logic [N_CH-1:0]  ssi_rst_q, ssi_rst_d;
  logic [N_CH-1:0]  underflow_q, underflow_d;
  logic             tick;

`ifndef ADRV9001_TDD_REPEAT_EN
  logic unused_frame_len;
  assign unused_frame_len = ^frame_len;
`endif

  always_comb begin
    tick         = (ps_q == PS_LAST);
    ps_d         = ps_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (!tdd_en) begin
      ps_d  = '0;
      cnt_d = '0;
    end else begin
      ps_d = tick ? '0 : ps_q + 1'b1;
      if (tick) begin
`ifdef ADRV9001_TDD_REPEAT_EN
        // Wrap reloads 1 so a running frame never shows the idle value 0.
        if ((frame_len != '0) && (cnt_q == frame_len)) begin
          cnt_d        = CNT_W'(1);
          frame_done_d = 1'b1;
        end else
`endif
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      enable_d[i]    = (rf_on_cnt[i*CNT_W +: CNT_W] < cnt_q) &&
                       (cnt_q <= rf_off_cnt[i*CNT_W +: CNT_W]);
      ssi_rst_d[i]   = !((ssi_on_cnt[i*CNT_W +: CNT_W] < cnt_q) &&
                         (cnt_q <= ssi_off_cnt[i*CNT_W +: CNT_W]));
      // A new underflow outranks a coincident clear.
      underflow_d[i] = (underflow_q[i] & ~underflow_clr) |
                       (s_axis_tready[i] & ~s_axis_tvalid[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ps_q         <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      enable_q     <= '0;
      ssi_rst_q    <= '1;
      underflow_q  <= '0;
    end else begin
      ps_q         <= ps_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      enable_q     <= enable_d;
      ssi_rst_q    <= ssi_rst_d;
      underflow_q  <= underflow_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      m_tdata[i*DATA_W +: DATA_W] = data_src[i] ? tdata[i*DATA_W +: DATA_W]
                                                : s_axis_tdata[i*DATA_W +: DATA_W];
    end
  end

  assign s_axis_tready = m_tready & ~ssi_rst_q & ~data_src;
  assign enable        = enable_q;
  assign ssi_rst       = ssi_rst_q;
  assign cnt           = cnt_q;
  assign frame_done    = frame_done_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_adrv9001_tdd_seq.sv
// tb/tb_adrv9001_tdd_seq.sv - randomized bench for adrv9001_tdd_seq against a tick-count reference model
module tb_adrv9001_tdd_seq;
  localparam int NC   = 2;
  localparam int CW   = 5;
  localparam int DW   = 16;
  localparam int PS   = 2;
  localparam int MAXC = (1 << CW) - 1;
`ifdef ADRV9001_TDD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic tdd_en = 1'b0;
  logic [CW-1:0] frame_len = '0;
  logic [NC*CW-1:0] rf_on = '0, rf_off = '0, ssi_on = '0, ssi_off = '0;
  logic [NC-1:0] data_src = '0, s_axis_tvalid = '1, m_tready = '1;
  logic [NC*DW-1:0] tdata = '0, s_axis_tdata = '0;
  logic underflow_clr = 1'b0;
  logic [NC-1:0] s_axis_tready, enable, ssi_rst, underflow;
  logic [NC*DW-1:0] m_tdata;
  logic [CW-1:0] cnt;
  logic frame_done;

  int n_chk = 0;
  int n_err = 0;

  adrv9001_tdd_seq #(.N_CH(NC), .CNT_W(CW), .DATA_W(DW), .PRESCALE(PS)) dut (
    .clk(clk), .rstn(rstn), .tdd_en(tdd_en), .frame_len(frame_len),
    .rf_on_cnt(rf_on), .rf_off_cnt(rf_off), .ssi_on_cnt(ssi_on), .ssi_off_cnt(ssi_off),
    .data_src(data_src), .tdata(tdata), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .m_tdata(m_tdata),
    .m_tready(m_tready), .enable(enable), .ssi_rst(ssi_rst), .cnt(cnt),
    .frame_done(frame_done), .underflow(underflow), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: count of consecutive edges with tdd_en high gives ticks = n/PS directly.
  function automatic logic [CW-1:0] f_cnt(input int n, input int len);
    int t;
    t = n / PS;
    if (REP && len != 0) return (t == 0) ? '0 : CW'((t - 1) % len + 1);
    return (t > MAXC) ? CW'(MAXC) : CW'(t);
  endfunction

  function automatic logic f_fd(input int n, input int len);
    int t;
    t = n / PS;
    return REP && (len != 0) && (n % PS == 0) && (t > len) && ((t - 1) % len == 0);
  endfunction

  function automatic logic win(input int on, input int off, input int c);
    return (on < c) && (c <= off);
  endfunction

  int m_n;
  logic [NC-1:0] m_en, m_rst, m_uf, e_rdy;
  logic [NC*DW-1:0] e_data;
  assign e_rdy = m_tready & ~m_rst & ~data_src;
  always_comb begin
    e_data = '0;
    for (int i = 0; i < NC; i++)
      e_data[i*DW +: DW] = data_src[i] ? tdata[i*DW +: DW] : s_axis_tdata[i*DW +: DW];
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_n <= 0; m_en <= '0; m_rst <= '1; m_uf <= '0;
    end else begin
      m_n <= tdd_en ? m_n + 1 : 0;
      for (int i = 0; i < NC; i++) begin
        m_en[i]  <= win(int'(rf_on[i*CW +: CW]), int'(rf_off[i*CW +: CW]), int'(f_cnt(m_n, int'(frame_len))));
        m_rst[i] <= !win(int'(ssi_on[i*CW +: CW]), int'(ssi_off[i*CW +: CW]), int'(f_cnt(m_n, int'(frame_len))));
        m_uf[i]  <= (m_uf[i] & ~underflow_clr) | (e_rdy[i] & ~s_axis_tvalid[i]);
      end
    end
  end

  always @(negedge clk) begin
    chk("cnt", 64'(cnt), 64'(f_cnt(m_n, int'(frame_len))));
    chk("frame_done", 64'(frame_done), 64'(f_fd(m_n, int'(frame_len))));
    chk("enable", 64'(enable), 64'(m_en));
    chk("ssi_rst", 64'(ssi_rst), 64'(m_rst));
    chk("underflow", 64'(underflow), 64'(m_uf));
    chk("tready", 64'(s_axis_tready), 64'(e_rdy));
    chk("m_tdata", 64'(m_tdata), 64'(e_data));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input int ron, input int roff, input int son, input int soff);
    rf_on[i*CW +: CW] = CW'(ron);   rf_off[i*CW +: CW] = CW'(roff);
    ssi_on[i*CW +: CW] = CW'(son);  ssi_off[i*CW +: CW] = CW'(soff);
  endtask

  task automatic stop_run();
    tdd_en = 1'b0;
    step();
    step();
  endtask

  task automatic async_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_enable", 64'(enable), 64'd0);
    chk("rst_ssi_rst", 64'(ssi_rst), 64'(2'b11));
    chk("rst_underflow", 64'(underflow), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    step();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int en_n, rdy_n, fd_n, k;
  logic [CW-1:0] cnt_h [0:40];
  logic fd_h [0:40];

  initial begin
    set_ch(0, 0, 10, 2, 8);
    set_ch(1, 3, 5, 0, 31);
    step();
    chk("reset_cnt", 64'(cnt), 64'd0);
    chk("reset_ssi_rst", 64'(ssi_rst), 64'(2'b11));
    chk("reset_enable", 64'(enable), 64'd0);
    rstn = 1'b1;
    step();

    // First tick lands PRESCALE-1 edges after tdd_en is first sampled.
    tdd_en = 1'b1;
    step();
    chk("edge0_cnt", 64'(cnt), 64'd0);
    step();
    chk("first_tick_cnt", 64'(cnt), 64'd1);
    en_n = 0; rdy_n = 0;
    for (int e = 2; e <= 41; e++) begin
      step();
      en_n += int'(enable[0]);
      rdy_n += int'(s_axis_tready[0]);
    end
    chk("enable_clks", 64'(en_n), 64'd20);
    chk("tready_clks", 64'(rdy_n), 64'd12);
    chk("no_underflow", 64'(underflow[0]), 64'd0);
    chk("cnt_after_41", 64'(cnt), 64'd21);
    stop_run();

    // Underflow: set on a valid gap, sticky, set beats clear.
    tdd_en = 1'b1;
    k = 0;
    while (ssi_rst[0] && k < 40) begin step(); k++; end
    chk("ssi_window_open", 64'(k < 40), 64'd1);
    s_axis_tvalid[0] = 1'b0;
    step();
    s_axis_tvalid[0] = 1'b1;
    step();
    chk("underflow_set", 64'(underflow[0]), 64'd1);
    s_axis_tvalid[0] = 1'b0;
    underflow_clr = 1'b1;
    step();
    chk("underflow_set_wins", 64'(underflow[0]), 64'd1);
    s_axis_tvalid[0] = 1'b1;
    step();
    chk("underflow_cleared", 64'(underflow[0]), 64'd0);
    underflow_clr = 1'b0;
    stop_run();

    // Drop tdd_en with cnt at 4.
    tdd_en = 1'b1;
    k = 0;
    while (cnt != 4 && k < 40) begin step(); k++; end
    chk("reached_cnt4", 64'(k < 40), 64'd1);
    tdd_en = 1'b0;
    step();
    chk("drop_cnt", 64'(cnt), 64'd0);
    chk("drop_enable_lag", 64'(enable[0]), 64'd1);
    step();
    chk("drop_enable", 64'(enable[0]), 64'd0);
    chk("drop_ssi_rst", 64'(ssi_rst), 64'(2'b11));

    // One-shot saturation.
    set_ch(0, 0, 31, 2, 8);
    tdd_en = 1'b1;
    repeat (70) step();
    chk("sat_cnt", 64'(cnt), 64'(MAXC));
    chk("sat_enable", 64'(enable[0]), 64'd1);
    repeat (5) step();
    chk("sat_hold", 64'(cnt), 64'(MAXC));
    stop_run();

    // Frame wrap at frame_len=5.
    frame_len = 5;
    tdd_en = 1'b1;
    fd_n = 0;
    for (int e = 0; e <= 40; e++) begin
      step();
      cnt_h[e] = cnt;
      fd_h[e] = frame_done;
      fd_n += int'(frame_done);
    end
`ifdef ADRV9001_TDD_REPEAT_EN
    chk("frame_cnt9", 64'(cnt_h[9]), 64'd5);
    chk("frame_wrap_cnt", 64'(cnt_h[11]), 64'd1);
    chk("frame_wrap_fd", 64'(fd_h[11]), 64'd1);
    chk("frame_fd_single", 64'(fd_h[12]), 64'd0);
    chk("frame_fd_count", 64'(fd_n), 64'd3);
`else
    chk("frame_cnt9", 64'(cnt_h[9]), 64'd5);
    chk("oneshot_cnt11", 64'(cnt_h[11]), 64'd6);
    chk("oneshot_fd", 64'(fd_h[11]), 64'd0);
    chk("oneshot_fd_count", 64'(fd_n), 64'd0);
`endif

    // Randomized runs.
    for (int r = 0; r < 24; r++) begin
      stop_run();
      frame_len = CW'($urandom_range(0, MAXC));
      for (int i = 0; i < NC; i++)
        set_ch(i, $urandom_range(0, MAXC), $urandom_range(0, MAXC),
               $urandom_range(0, MAXC), $urandom_range(0, MAXC));
      if (r % 3 == 0) frame_len = CW'($urandom_range(1, 6));
      tdd_en = 1'b1;
      k = $urandom_range(5, 90);
      for (int c = 0; c < k; c++) begin
        data_src      = NC'($urandom_range(0, 3));
        m_tready      = NC'($urandom_range(0, 3));
        s_axis_tvalid = ($urandom_range(0, 5) == 0) ? NC'($urandom_range(0, 3)) : '1;
        underflow_clr = ($urandom_range(0, 7) == 0);
        tdata         = (NC*DW)'($urandom);
        s_axis_tdata  = (NC*DW)'($urandom);
        if (r % 4 == 1 && c == k / 2) async_reset();
        else step();
      end
    end
    stop_run();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
